// File: rtl/mpe_result_packer_pkg.sv
// Shared definitions for the matrix PE result path: lane count, word width
// and the ReLU clamp applied to PE results.
package mpe_result_packer_pkg;

  localparam int MPE_LANES  = 16;
  localparam int MPE_WORD_W = 32;

  typedef logic signed [MPE_WORD_W-1:0] mpe_word_t;

  function automatic mpe_word_t mpe_relu(input mpe_word_t x, input logic en);
    return (en && x[MPE_WORD_W-1]) ? '0 : x;
  endfunction

endpackage

// File: rtl/mpe_result_packer_if.sv
// Result stream in, packed line stream out. The packer is the slave side.
interface mpe_result_packer_if
  import mpe_result_packer_pkg::*;
#(
  parameter int LANES  = MPE_LANES,
  parameter int ADDR_W = 10
);

  mpe_word_t                      mpe_result;
  logic                           mpe_result_vld;
  logic [MPE_WORD_W*LANES-1:0]    out_data;
  logic [LANES-1:0]               out_mask;
  logic [ADDR_W-1:0]              out_addr;
  logic                           out_valid;
  logic                           out_ready;

  modport master (
    output mpe_result, mpe_result_vld, out_ready,
    input  out_data, out_mask, out_addr, out_valid
  );

  modport slave (
    input  mpe_result, mpe_result_vld, out_ready,
    output out_data, out_mask, out_addr, out_valid
  );

endinterface

// File: rtl/mpe_line_fifo.sv
// Two-entry shift FIFO; ent0 is always the head, empty slots are held at zero.
module mpe_line_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             not_empty,
  output logic             full
);

  logic [WIDTH-1:0] ent0, ent1;
  logic [1:0]       cnt;
  logic             pop_en, push_en;

  assign pop_en  = pop && (cnt != 2'd0);
  // A push into a full queue only lands when the head leaves the same cycle.
  assign push_en = push && ((cnt != 2'd2) || pop_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= 2'd0;
    end else if (clr) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= 2'd0;
    end else begin
      case ({push_en, pop_en})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= wr_data;
          else             ent1 <= wr_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          ent1 <= '0;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            ent0 <= wr_data;
          end else begin
            ent0 <= ent1;
            ent1 <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_data   = ent0;
  assign not_empty = (cnt != 2'd0);
  assign full      = (cnt == 2'd2);

endmodule

// File: rtl/mpe_result_packer.sv
// Packs a stream of PE results into LANES-wide lines with a fill mask and
// queues them, with incrementing line addresses, for a ready/valid sink.
module mpe_result_packer
  import mpe_result_packer_pkg::*;
#(
  parameter int LANES  = MPE_LANES,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  mpe_result_packer_if.slave  bus,
  input  logic                cfg_start,
  input  logic [ADDR_W-1:0]   cfg_base_addr,
  input  logic                cfg_relu,
  input  logic                flush,
  output logic                overflow,
  output logic                busy
);

  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int LINE_W = MPE_WORD_W * LANES;
  localparam int ENT_W  = LINE_W + LANES;

  logic [LW-1:0]     lane_cnt;
  logic [LANES-1:0]  fill_mask;
  logic [LINE_W-1:0] asm_data;
  logic [ADDR_W-1:0] addr_q;

  mpe_word_t         word;
  logic [LINE_W-1:0] nxt_data;
  logic [LANES-1:0]  nxt_mask;
  logic              last, push, pop, drop;
  logic              fifo_full, fifo_ne;
  logic [ENT_W-1:0]  fifo_rd;

  always_comb begin
    word     = mpe_relu(bus.mpe_result, cfg_relu);
    nxt_data = asm_data;
    nxt_mask = fill_mask;
    for (int i = 0; i < LANES; i++) begin
      if (bus.mpe_result_vld && (lane_cnt == LW'(i))) begin
        nxt_data[MPE_WORD_W*i +: MPE_WORD_W] = word;
        nxt_mask[i]                          = 1'b1;
      end
    end
    last = bus.mpe_result_vld && (lane_cnt == LW'(LANES-1));
    // A flush that coincides with a result packs that result first, so the
    // line is non-empty whenever either a lane is already filled or one lands now.
    push = !cfg_start && (last || (flush && ((lane_cnt != '0) || bus.mpe_result_vld)));
    pop  = !cfg_start && fifo_ne && bus.out_ready;
    drop = push && fifo_full && !pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt  <= '0;
      fill_mask <= '0;
      asm_data  <= '0;
      addr_q    <= '0;
      overflow  <= 1'b0;
    end else if (cfg_start) begin
      lane_cnt  <= '0;
      fill_mask <= '0;
      asm_data  <= '0;
      addr_q    <= cfg_base_addr;
      overflow  <= 1'b0;
    end else begin
      if (push) begin
        lane_cnt  <= '0;
        fill_mask <= '0;
        asm_data  <= '0;
      end else if (bus.mpe_result_vld) begin
        lane_cnt  <= lane_cnt + LW'(1);
        fill_mask <= nxt_mask;
        asm_data  <= nxt_data;
      end
      if (pop)  addr_q   <= addr_q + ADDR_W'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  mpe_line_fifo #(.WIDTH(ENT_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cfg_start),
    .push      (push),
    .wr_data   ({nxt_data, nxt_mask}),
    .pop       (pop),
    .rd_data   (fifo_rd),
    .not_empty (fifo_ne),
    .full      (fifo_full)
  );

  assign bus.out_data  = fifo_rd[ENT_W-1:LANES];
  assign bus.out_mask  = fifo_rd[LANES-1:0];
  assign bus.out_addr  = addr_q;
  assign bus.out_valid = fifo_ne;
  assign busy          = (lane_cnt != '0) || fifo_ne;

endmodule

// File: doc/mpe_result_packer.md
MPE_RESULT_PACKER -- requirements
Module: mpe_result_packer

Interface
REQ-001 SHALL have parameters: LANES, default 16, 32-bit results per output line; ADDR_W, default 10, output line address width.
REQ-002 SHALL have ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mpe_result  in  32  signed result from matrix PE.
- mpe_result_vld  in  1  result valid, one-cycle pulse per result, no backpressure.
- cfg_start  in  1  pulse: begin new tile, load base address.
- cfg_base_addr  in  ADDR_W  first line address, sampled on cfg_start.
- cfg_relu  in  1  level: clamp negative results to 0.
- flush  in  1  pulse: emit partially filled line.
- out_data  out  32*LANES  packed line.
- out_mask  out  LANES  per-lane valid mask.
- out_addr  out  ADDR_W  line write address.
- out_valid  out  1  line available.
- out_ready  in  1  sink accepts line.
- overflow  out  1  sticky: a line was dropped.
- busy  out  1  partial line or queued lines present.

Function
REQ-003 SHALL hold an assembly register of LANES words, a lane counter (0..LANES-1) and a per-lane fill mask.
REQ-004 SHALL, on mpe_result_vld, write the result, after optional ReLU, into lane[lane_cnt] (bits 32*lane+31:32*lane), set that mask bit, and increment lane_cnt.
REQ-005 ReLU SHALL, when cfg_relu=1 and mpe_result[31]=1, store 32'h0; otherwise store mpe_result unchanged.
REQ-006 Accepting a result at lane LANES-1 SHALL complete the line: push data with the all-ones mask into the queue, clear the assembly mask, and wrap lane_cnt to 0.
REQ-007 flush with lane_cnt!=0 SHALL push the partial line with its fill mask; unfilled lanes SHALL be zero; lane_cnt and mask SHALL clear.
REQ-008 flush with lane_cnt==0 and no line completing SHALL be a no-op.
REQ-009 flush coincident with mpe_result_vld SHALL include that result before the flush; if that result completes the line, exactly one full line SHALL be pushed.
REQ-010 The output queue SHALL be a 2-entry FIFO of {data, mask}; out_valid SHALL be 1 iff it is non-empty; out_data/out_mask SHALL show the head entry.
REQ-011 A transfer SHALL occur when out_valid&&out_ready; the head SHALL pop and out_addr SHALL increment by 1, wrapping modulo 2^ADDR_W.
REQ-012 A line pushed at edge N SHALL be presented with out_valid=1 from cycle N+1, giving 1-cycle latency.
REQ-013 Push and pop in the same cycle SHALL be allowed when the queue is full.
REQ-014 A push to a full queue with no pop that cycle SHALL drop the new line and set overflow; the queue contents and out_addr SHALL be unchanged.
REQ-015 cfg_start SHALL clear the queue, lane_cnt, mask and overflow, and load out_addr with cfg_base_addr; it SHALL override all other inputs that cycle, and a coincident result SHALL be discarded.
REQ-016 busy SHALL be (lane_cnt!=0) || out_valid, computed combinationally from registers.
REQ-017 out_data/out_mask SHALL be held stable while out_valid=1 and out_ready=0.

Reset
REQ-018 On rst_n=0 the block SHALL immediately force: lane_cnt, mask, assembly data and queue to 0; out_valid, overflow and busy to 0; out_addr to 0; out_data and out_mask to 0.
REQ-019 Reset mid-line or mid-queue SHALL discard all pending data without emitting it.

Structure
REQ-020 LANES, the 32-bit word width and the ReLU function SHALL live in a shared package used with the matrix PE.
REQ-021 The 2-entry queue SHALL be one sub-module, mpe_line_fifo, parameterised by entry width; packing and addressing SHALL stay in the top module.

Verification
REQ-022 Base 0x010, relu=0, 16 results 1..16, out_ready=1 -> one line with lane0=1 and lane15=16, mask 16'hFFFF, addr 0x010, out_valid asserted the cycle after the 16th result.
REQ-023 relu=1, results -5, 7 then flush -> line lane0=0, lane1=7, mask 16'h0003, lanes 2-15 zero.
REQ-024 out_ready=0, 48 results -> 2 lines queued, third line dropped, overflow=1; after out_ready=1, addrs base and base+1 emitted, then out_valid=0.
REQ-025 Base 0x3FF, 32 results, out_ready=1 -> addrs 0x3FF then 0x000.
REQ-026 Flush coincident with the 16th result -> exactly one full line, mask 16'hFFFF, no empty line pushed.
REQ-027 Assert rst_n low after 5 results, then run 16 results -> no line from the first 5; next line holds the 16 new values at addr 0.
